sprite_line_renderer: RTL
=========================

# sprite_line_renderer

Sequential scanline sprite renderer for the GPU. During horizontal blanking it walks the sprite attribute table from highest to lowest index and tests each sprite against the requested scan line. For each intersecting sprite it fetches one 8-pixel tile row per tile column from tile memory and writes the opaque, on-screen pixels into the line buffer. Because lower-indexed sprites are drawn last, they overwrite higher-indexed ones.

## Interface
- NUM_SPRITES, 64: number of attribute entries; index width is clog2(NUM_SPRITES).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and zeroes all outputs.
- start  in  1  one-cycle pulse; begins rendering `line_y`. Sampled only in IDLE.
- line_y  in  10  scan line to render; latched on an accepted `start`.
- busy  out  1  high from the cycle after an accepted `start` through the DONE state.
- done  out  1  one-cycle pulse when the line is complete.
- attr_addr  out  clog2(NUM_SPRITES)  sprite attribute index.
- attr_data  in  49  sprite attributes, packed as {x[15:0] signed, y[15:0] signed, size_x[2:0], size_y[2:0], vflip, tile_x[3:0], tile_y[3:0]}. Valid one cycle after `attr_addr`.
- tile_req  out  1  tile-row read request; held until acknowledged.
- tile_addr  out  11  {tile_row[3:0], tile_col[3:0], row_off[2:0]}; stable while `tile_req` is high.
- tile_ack  in  1  read acknowledge; `tile_data` is valid in the same cycle.
- tile_data  in  32  8 pixels × 4 bits; bits [31:28] are the leftmost pixel (i=0).
- lb_we  out  1  line buffer write strobe; one pixel per cycle.
- lb_addr  out  10  pixel x coordinate, 0..639.
- lb_data  out  4  pixel colour index.

## Operation
- States: IDLE, ATTR_REQ, ATTR_WAIT, EVAL, TILE_REQ, TILE_WAIT, PIXEL, NEXT, DONE.
- IDLE: on `start`, latch `line_y`, set idx=NUM_SPRITES-1, go to ATTR_REQ. A `start` seen in any other state is ignored.
- ATTR_REQ: drive `attr_addr`=idx.
- ATTR_WAIT: latch `attr_data` into local registers.
- EVAL: compute the intersect test and row values. If the sprite intersects, set col=0 and go to TILE_REQ; otherwise go to NEXT.
  - height = 8·(size_y+1)−1.
  - Intersect iff y ≤ L ≤ y+height, using 17-bit signed compares with L = zero-extended `line_y`.
  - n = L−y (7 bits); if vflip, n = height−n.
  - tile_row = tile_y + n[6:3] (mod 16); row_off = n[2:0].
- TILE_REQ/TILE_WAIT:
  - `tile_req`=1 with tile_addr = {tile_row, (tile_x+col) mod 16, row_off}.
  - On `tile_ack`, latch `tile_data`, drop `tile_req` on the next cycle, set i=0, go to PIXEL.
- PIXEL: 8 cycles, i=0..7.
  - px = x + 8·col + i, computed as 16-bit signed.
  - lb_we = (pixel≠0) && 0 ≤ px ≤ 639; lb_addr = px[9:0]; lb_data = pixel.
  - After i=7: if col<size_x, increment col and go to TILE_REQ; otherwise go to NEXT.
- Colour 0 is transparent and is never written.
- The block performs no clipping-driven skips. Every tile column is fetched even when it is fully off-screen; its writes are simply suppressed.
- NEXT: if idx=0 go to DONE; otherwise decrement idx and go to ATTR_REQ.
- DONE: `done`=1 for one cycle, then IDLE.
- Reset, including mid-operation, takes effect on the next edge:
  - state=IDLE; busy, done, tile_req, lb_we = 0.
  - attr_addr, tile_addr, lb_addr, lb_data = 0.
  - A `tile_ack` arriving after reset is ignored.

## Timing
- All outputs are registered.
- `start` is accepted at edge 0; ATTR_REQ and `busy` are visible in cycle 1.
- A non-intersecting sprite costs 4 cycles (ATTR_REQ, ATTR_WAIT, EVAL, NEXT).
- An intersecting sprite costs 4 + (size_x+1)·(9+W) cycles, where W = wait cycles before `tile_ack`.
  - With ack in the first TILE_REQ cycle, W=0: TILE_REQ(1) + PIXEL(8).
- Worst case (64 sprites, 8 columns each, W=0): 64·(4+72)+1 cycles. Budgeting line time is the caller's responsibility.
- `tile_ack` while `tile_req`=0 is ignored.

## Test plan
- Basic draw:
  - Stimulus: sprite 63 at x=0, y=10, size 0/0, tile_x=2, tile_y=1, line 10, tile_data=0x12345678, other sprites at y=500.
  - Response: tile_addr={1,2,0}; lb writes at addr 0..7 with data 1..8; done pulses.
- Transparency:
  - Stimulus: same sprite, tile_data=0x10203040.
  - Response: writes only at addr 0,2,4,6 with data 1,2,3,4.
- Clipping:
  - Stimulus A: x=−4, size_x=0. Response: writes only at addr 0..3 with pixels i=4..7.
  - Stimulus B: x=636. Response: writes only at addr 636..639. Both fetches still issued.
- vflip:
  - Stimulus: y=0, size_y=1, vflip=1, line 3, tile_y=5.
  - Response: tile_addr row=6, row_off=4. With vflip=0: row=5, row_off=3.
- Idle line and priority:
  - Stimulus A: no sprite intersects, NUM_SPRITES=64. Response: done exactly 257 cycles after the start edge.
  - Stimulus B: sprites 5 and 3 overlap at addr 0. Response: the last write to addr 0 carries sprite 3's colour.
- Reset mid-fetch:
  - Stimulus: reset asserted while `tile_req`=1.
  - Response: next cycle busy=0, tile_req=0, lb_we=0; a following `tile_ack` produces no writes; a new `start` renders correctly.

Source files
------------

// File: rtl/sprite_line_renderer.sv
// Scanline sprite renderer: walks attributes high->low index, fetches tile rows, writes opaque on-screen pixels.
// Latency 4 cycles per missed sprite, 4+(size_x+1)*(9+W) per hit; fetches stall on tile_ack, line buffer never stalls.
module sprite_line_renderer #(
    parameter int NUM_SPRITES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [9:0]                     line_y,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
    input  logic [48:0]                    attr_data,
    output logic                           tile_req,
    output logic [10:0]                    tile_addr,
    input  logic                           tile_ack,
    input  logic [31:0]                    tile_data,
    output logic                           lb_we,
    output logic [9:0]                     lb_addr,
    output logic [3:0]                     lb_data
);
    localparam int IW = $clog2(NUM_SPRITES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);

    typedef enum logic [3:0] {
        IDLE, ATTR_REQ, ATTR_WAIT, EVAL, TILE_REQ, TILE_WAIT, PIXEL, NEXT, DONE
    } state_t;

    // Attribute word is LSB-aligned; the top two bits carry nothing.
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [2:0]         size_x;
        logic [2:0]         size_y;
        logic               vflip;
        logic [3:0]         tile_x;
        logic [3:0]         tile_y;
    } attr_t;

    state_t         state_q, state_d;
    logic [9:0]     line_q, line_d;
    attr_t          attr_q, attr_d;
    logic [2:0]     col_q, col_d;
    logic [2:0]     i_q, i_d;
    logic [31:0]    pix_q, pix_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [IW-1:0]  attr_addr_q, attr_addr_d;
    logic           tile_req_q, tile_req_d;
    logic [10:0]    tile_addr_q, tile_addr_d;
    logic           lb_we_q, lb_we_d;
    logic [9:0]     lb_addr_q, lb_addr_d;
    logic [3:0]     lb_data_q, lb_data_d;

    logic           unused_attr_bits;
    logic [5:0]     height;
    logic [16:0]    y_top, y_bot, l_ext;
    logic           hit;
    logic [6:0]     n_fwd, n_row;
    logic [3:0]     row_c;
    logic [15:0]    px;
    logic           px_on;
    logic [2:0]     col_nx;

    assign unused_attr_bits = ^attr_data[48:47];

    assign height = {attr_q.size_y, 3'b111};
    assign y_top  = {attr_q.y[15], attr_q.y};
    assign y_bot  = y_top + {11'd0, height};
    assign l_ext  = {7'd0, line_q};
    assign hit    = ($signed(y_top) <= $signed(l_ext)) && ($signed(l_ext) <= $signed(y_bot));
    // Only the low 7 bits of L-y matter once the sprite is known to intersect.
    assign n_fwd  = line_q[6:0] - attr_q.y[6:0];
    assign n_row  = attr_q.vflip ? ({1'b0, height} - n_fwd) : n_fwd;
    assign row_c  = attr_q.tile_y + n_row[6:3];

    assign px     = attr_q.x + {10'd0, col_q, 3'd0} + {13'd0, i_q};
    assign px_on  = !px[15] && (px <= 16'd639);
    assign col_nx = col_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        attr_d      = attr_q;
        col_d       = col_q;
        i_d         = i_q;
        pix_d       = pix_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        attr_addr_d = attr_addr_q;
        tile_req_d  = tile_req_q;
        tile_addr_d = tile_addr_q;
        lb_we_d     = 1'b0;
        lb_addr_d   = lb_addr_q;
        lb_data_d   = lb_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    line_d      = line_y;
                    attr_addr_d = LAST_IDX;
                    busy_d      = 1'b1;
                    state_d     = ATTR_REQ;
                end
            end
            ATTR_REQ:  state_d = ATTR_WAIT;
            ATTR_WAIT: begin
                attr_d  = attr_data[46:0];
                state_d = EVAL;
            end
            EVAL: begin
                if (hit) begin
                    col_d       = 3'd0;
                    tile_req_d  = 1'b1;
                    tile_addr_d = {row_c, attr_q.tile_x, n_row[2:0]};
                    state_d     = TILE_REQ;
                end else begin
                    state_d = NEXT;
                end
            end
            TILE_REQ, TILE_WAIT: begin
                if (tile_ack) begin
                    pix_d      = tile_data;
                    tile_req_d = 1'b0;
                    i_d        = 3'd0;
                    state_d    = PIXEL;
                end else begin
                    state_d = TILE_WAIT;
                end
            end
            PIXEL: begin
                lb_we_d   = (pix_q[31:28] != 4'd0) && px_on;
                lb_addr_d = px[9:0];
                lb_data_d = pix_q[31:28];
                pix_d     = pix_q << 4;
                i_d       = i_q + 3'd1;
                if (i_q == 3'd7) begin
                    if (col_q < attr_q.size_x) begin
                        col_d       = col_nx;
                        tile_req_d  = 1'b1;
                        tile_addr_d = {tile_addr_q[10:7], attr_q.tile_x + {1'b0, col_nx}, tile_addr_q[2:0]};
                        state_d     = TILE_REQ;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (attr_addr_q == '0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    attr_addr_d = attr_addr_q - 1'b1;
                    state_d     = ATTR_REQ;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            line_q      <= '0;
            attr_q      <= '0;
            col_q       <= '0;
            i_q         <= '0;
            pix_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            attr_addr_q <= '0;
            tile_req_q  <= 1'b0;
            tile_addr_q <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            attr_q      <= attr_d;
            col_q       <= col_d;
            i_q         <= i_d;
            pix_q       <= pix_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            attr_addr_q <= attr_addr_d;
            tile_req_q  <= tile_req_d;
            tile_addr_q <= tile_addr_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            lb_data_q   <= lb_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign attr_addr = attr_addr_q;
    assign tile_req  = tile_req_q;
    assign tile_addr = tile_addr_q;
    assign lb_we     = lb_we_q;
    assign lb_addr   = lb_addr_q;
    assign lb_data   = lb_data_q;
endmodule
